fibonacci_lfsr_checker: RTL and testbench

Serial PRBS checker for streams produced by the team's Fibonacci LFSR generator, one bit per enabled cycle from the generator's `value[0]`. It self-synchronises to the incoming stream with no shared seed. After lock it free-runs its own LFSR, flags each mismatching bit and counts errors. It sits at the receive end of link, SerDes and memory BIST paths, opposite the generator.

---
 rtl/fibonacci_lfsr_checker.sv | 136 +++++++++++++
 tb/tb_fibonacci_lfsr_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fibonacci_lfsr_checker.sv
// fibonacci_lfsr_checker: self-synchronising serial PRBS checker for Fibonacci LFSR streams
//   clock_i        rising-edge clock
//   reset_i        synchronous active-high reset
//   enable_i       data_in_i carries a valid bit this cycle
//   data_in_i      received serial bit, generator value[0] order
//   clear_i        synchronous clear of error_count_o, wins over an increment
//   locked_o       checker synchronised to the stream
//   error_o        one-cycle pulse, last enabled bit mismatched while locked
//   error_count_o  saturating count of locked-state mismatches
module fibonacci_lfsr_checker #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'b00011101,
    parameter int LOCK_COUNT = 16,
    parameter int UNLOCK_ERRORS = 4,
    parameter int ERROR_COUNTER_WIDTH = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic                           data_in_i,
    input  logic                           clear_i,
    output logic                           locked_o,
    output logic                           error_o,
    output logic [ERROR_COUNTER_WIDTH-1:0] error_count_o
);
    localparam logic [1:0] SEED   = 2'd0;
    localparam logic [1:0] HUNT   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_ERRORS + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
    localparam logic [MW-1:0] RUN_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRORS - 1);

    logic [1:0]                     state_q, state_d;
    logic [WIDTH-1:0]               h_q, h_d;
    logic [FW-1:0]                  fill_q, fill_d;
    logic [MW-1:0]                  match_q, match_d;
    logic [MW-1:0]                  run_q, run_d;
    logic [BW-1:0]                  bad_q, bad_d;
    logic                           locked_q, locked_d;
    logic                           error_q, error_d;
    logic [ERROR_COUNTER_WIDTH-1:0] count_q, count_d;
    logic                           p, hit;

    assign p   = ^(h_q & TAPS);
    assign hit = data_in_i == p;

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        fill_d   = fill_q;
        match_d  = match_q;
        run_d    = run_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        error_d  = 1'b0;
        count_d  = count_q;
        if (enable_i) begin
            // once locked the history free-runs on its own prediction
            h_d = {state_q == LOCKED ? p : data_in_i, h_q[WIDTH-1:1]};
            case (state_q)
                SEED: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                HUNT: begin
                    // an all-zero history predicts zeros forever, so never count it as a match
                    if (hit && h_q != '0) begin
                        if (match_q == RUN_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            bad_d    = '0;
                            run_d    = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                default: begin
                    if (hit) begin
                        run_d = run_q == RUN_LAST ? '0 : run_q + 1'b1;
                        bad_d = run_q == RUN_LAST ? '0 : bad_q;
                    end else begin
                        error_d = 1'b1;
                        count_d = &count_q ? count_q : count_q + 1'b1;
                        run_d   = '0;
                        if (bad_q == BAD_LAST) begin
                            state_d  = SEED;
                            fill_d   = '0;
                            locked_d = 1'b0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                end
            endcase
        end
        if (clear_i) count_d = '0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= SEED;
            h_q      <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            run_q    <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            run_q    <= run_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    assign locked_o      = locked_q;
    assign error_o       = error_q;
    assign error_count_o = count_q;
endmodule

// File: tb/tb_fibonacci_lfsr_checker.sv
// tb_fibonacci_lfsr_checker: scoreboard bench for the default and a small-counter checker
module tb_fibonacci_lfsr_checker;
    localparam logic [7:0] T = 8'b00011101;

    typedef struct {
        bit          sel;
        bit          lk;
        bit          er;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en1 = 1'b0, d1 = 1'b0, clr1 = 1'b0;
    logic        en2 = 1'b0, d2 = 1'b0, clr2 = 1'b0;
    logic        lk1, er1, lk2, er2;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;
    logic [7:0]  g;
    exp_t        sb[$];
    string       phase = "init";
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fibonacci_lfsr_checker u_dut (
        .clock_i(clk), .reset_i(rst), .enable_i(en1), .data_in_i(d1), .clear_i(clr1),
        .locked_o(lk1), .error_o(er1), .error_count_o(cnt1)
    );

    fibonacci_lfsr_checker #(.UNLOCK_ERRORS(8), .ERROR_COUNTER_WIDTH(4)) u_sat (
        .clock_i(clk), .reset_i(rst), .enable_i(en2), .data_in_i(d2), .clear_i(clr2),
        .locked_o(lk2), .error_o(er2), .error_count_o(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_bit(output bit b);
        b = g[0];
        g = {^(g & T), g[7:1]};
    endtask

    task automatic step(input bit sel, input bit en, input bit d, input bit clr,
                        input bit lk, input bit er, input logic [15:0] cnt);
        exp_t e;
        @(negedge clk);
        en1  = sel ? 1'b0 : en;
        d1   = sel ? 1'b0 : d;
        clr1 = sel ? 1'b0 : clr;
        en2  = sel ? en : 1'b0;
        d2   = sel ? d : 1'b0;
        clr2 = sel ? clr : 1'b0;
        sb.push_back('{sel, lk, er, cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({phase, ".locked"}, e.sel ? 32'(lk2) : 32'(lk1), 32'(e.lk));
        check({phase, ".error"}, e.sel ? 32'(er2) : 32'(er1), 32'(e.er));
        check({phase, ".count"}, e.sel ? 32'(cnt2) : 32'(cnt1), 32'(e.cnt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit b, f;
        int n, nf;
        phase = "reset_idle";
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        phase = "clean_lock";
        g = 8'd1;
        for (int i = 1; i <= 1000; i++) begin
            next_bit(b);
            step(0, 1, b, 0, i >= 24, 0, 0);
        end

        phase = "single_flip";
        for (int i = 1; i <= 200; i++) begin
            next_bit(b);
            f = i == 100;
            step(0, 1, b ^ f, 0, 1, f, i >= 100 ? 16'd1 : 16'd0);
        end

        phase = "burst";
        step(0, 0, 0, 1, 1, 0, 0);
        nf = 0;
        for (int i = 1; i <= 80; i++) begin
            next_bit(b);
            f = i == 10 || i == 12 || i == 15 || i == 19;
            nf += int'(f);
            step(0, 1, b ^ f, 0, i < 19 || i >= 43, f, 16'(nf));
        end

        phase = "spaced_flips";
        step(0, 0, 0, 1, 1, 0, 0);
        nf = 0;
        for (int i = 1; i <= 80; i++) begin
            next_bit(b);
            f = i == 10 || i == 27 || i == 44;
            nf += int'(f);
            step(0, 1, b ^ f, 0, 1, f, 16'(nf));
        end

        phase = "reset_mid_lock";
        rst = 1'b1;
        step(0, 1, 1, 0, 0, 0, 0);
        rst = 1'b0;

        phase = "gapped_lock";
        g = 8'd1;
        n = 0;
        for (int c = 0; c < 400 && n < 40; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                next_bit(b);
                n++;
                step(0, 1, b, 0, n >= 24, 0, 0);
            end else begin
                step(0, 0, 1'($urandom_range(0, 1)), 0, n >= 24, 0, 0);
            end
        end
        check("gapped_lock.bits", 32'(n), 32'd40);

        phase = "all_zero";
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 200; i++) step(0, 1, 0, 0, 0, 0, 0);

        phase = "saturate";
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        g = 8'd1;
        for (int i = 1; i <= 24; i++) begin
            next_bit(b);
            step(1, 1, b, 0, i >= 24, 0, 0);
        end
        nf = 0;
        for (int i = 1; i <= 400; i++) begin
            next_bit(b);
            f = i % 20 == 0;
            nf += int'(f);
            step(1, 1, b ^ f, 0, 1, f, nf > 15 ? 16'd15 : 16'(nf));
        end

        phase = "clear_vs_error";
        for (int i = 1; i <= 19; i++) begin
            next_bit(b);
            step(1, 1, b, 0, 1, 0, 15);
        end
        next_bit(b);
        step(1, 1, ~b, 1, 1, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            next_bit(b);
            step(1, 1, b, 0, 1, 0, 0);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
